// File: rtl/start_timer_sequencer.sv
// Avalon-MM programmable tick sequencer started by a synchronised PIO level or a register write.
// Runs REPEAT+1 periods of PERIOD+1 clocks, pulsing tick_out at each period end.
module start_timer_sequencer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        start_in,
  output logic        tick_out,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrPeriod = 3'd1;
  localparam logic [2:0] AddrRepeat = 3'd2;
  localparam logic [2:0] AddrCount  = 3'd3;
  localparam logic [2:0] AddrStatus = 3'd4;
  localparam logic [2:0] AddrLeft   = 3'd5;

  state_e state_q, state_d;

  logic        en_q, cont_q, irq_en_q;
  logic [31:0] period_q;
  logic [15:0] repeat_q;
  logic [31:0] count_q, count_d;
  logic [15:0] left_q, left_d;
  logic        done_q, overrun_q;
  logic        sw_start_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        sync_d1_q, sync_d2_q, start_rise_q;

  logic wr, wr_ctrl, wr_status;
  logic abort_req, sw_start_d, trig;
  logic set_done, set_overrun;

  // Bus decode
  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr & (address == AddrCtrl);
  assign wr_status = wr & (address == AddrStatus);

  // Clearing EN through a CTRL write stops a run exactly like ABORT does.
  assign abort_req  = wr_ctrl & (writedata[4] | ~writedata[0]);
  assign sw_start_d = wr_ctrl & writedata[3] & ~writedata[4];
  assign trig       = en_q & (start_rise_q | sw_start_q);

  // Edge pulse lands SYNC_STAGES+1 cycles after the equivalent SW_START pulse slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      sync_d1_q    <= 1'b0;
      sync_d2_q    <= 1'b0;
      start_rise_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], start_in};
      sync_d1_q    <= sync_q[SYNC_STAGES-1];
      sync_d2_q    <= sync_d1_q;
      start_rise_q <= sync_d1_q & ~sync_d2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    left_d      = left_q;
    set_done    = 1'b0;
    set_overrun = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig && !abort_req) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (abort_req) begin
          state_d = StIdle;
        end else begin
          count_d = period_q;
          left_d  = repeat_q;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort_req) begin
          state_d = StIdle;
        end else if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else if (left_q != 16'd0) begin
          left_d  = left_q - 16'd1;
          count_d = period_q;
        end else if (cont_q) begin
          state_d = StLoad;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        set_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (trig && (state_q == StLoad || state_q == StRun)) begin
      set_overrun = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      left_q  <= left_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= 1'b0;
      cont_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      period_q   <= '0;
      repeat_q   <= '0;
      sw_start_q <= 1'b0;
    end else begin
      sw_start_q <= sw_start_d;
      if (wr_ctrl) begin
        en_q     <= writedata[0];
        cont_q   <= writedata[1];
        irq_en_q <= writedata[2];
      end
      if (wr && address == AddrPeriod) begin
        period_q <= writedata;
      end
      if (wr && address == AddrRepeat) begin
        repeat_q <= writedata[15:0];
      end
    end
  end

  // Sticky flags: a set in the same cycle as a W1C wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= set_done | (done_q & ~(wr_status & writedata[1]));
      overrun_q <= set_overrun | (overrun_q & ~(wr_status & writedata[2]));
    end
  end

  assign busy     = (state_q == StLoad) || (state_q == StRun);
  assign tick_out = (state_q == StRun) && (count_q == 32'd0);
  assign irq      = irq_en_q & done_q;

  always_comb begin
    readdata = 32'd0;
    unique case (address)
      AddrCtrl:   readdata = {29'd0, irq_en_q, cont_q, en_q};
      AddrPeriod: readdata = period_q;
      AddrRepeat: readdata = {16'd0, repeat_q};
      AddrCount:  readdata = count_q;
      AddrStatus: readdata = {29'd0, overrun_q, done_q, busy};
      AddrLeft:   readdata = {16'd0, left_q};
      default:    readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_start_timer_sequencer.sv
// Scoreboard bench for start_timer_sequencer: expected tick cycles are queued by the stimulus
// and popped by a tick monitor; register reads are checked against hand-computed values.
module tb_start_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        start_in = 1'b0;
  logic        tick_out, busy, irq;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_q[$];

  start_timer_sequencer #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .start_in   (start_in),
    .tick_out   (tick_out),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tick monitor: every tick must match the next queued cycle number.
  always @(negedge clk) begin
    if (reset_n && tick_out) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tick: unexpected tick at cyc=%0d, none expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL tick: got tick at cyc=%0d, wanted cyc=%0d", cyc, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    chk(nm, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int c;
    // Reset state
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tick", {31'd0, tick_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(3'd4, 32'd0, "rst_status");
    rd(3'd0, 32'd0, "rst_ctrl");
    @(negedge clk);
    reset_n = 1'b1;

    // Register access; REPEAT keeps only 16 bits, unmapped reads 0
    wr(3'd1, 32'd4);
    wr(3'd2, 32'hFFFF_0002);
    wr(3'd0, 32'h5);
    rd(3'd1, 32'd4, "period_rd");
    rd(3'd2, 32'd2, "repeat_rd");
    rd(3'd0, 32'd5, "ctrl_rd");
    rd(3'd7, 32'd0, "unmapped_rd");

    // SW_START, PERIOD=4 REPEAT=2, IRQ_EN
    wr(3'd0, 32'hD);
    k = cyc;
    exp_q.push_back(k + 6);
    exp_q.push_back(k + 11);
    exp_q.push_back(k + 16);
    wait_until(k + 3);
    rd(3'd3, 32'd3, "count_mid");
    rd(3'd5, 32'd2, "left_mid");
    chk("busy_mid", {31'd0, busy}, 32'd1);
    wait_until(k + 17);
    rd(3'd4, 32'd0, "status_pre_done");
    wait_until(k + 18);
    rd(3'd4, 32'd2, "status_done");
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(3'd4, 32'd2);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd(3'd4, 32'd0, "status_w1c");

    // start_in edge, PERIOD=0 REPEAT=0, then held high
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd0, 32'h1);
    @(posedge clk);
    #3 start_in = 1'b1;
    c = cyc;
    exp_q.push_back(c + 6);
    wait_until(c + 20);
    rd(3'd4, 32'd2, "pio_done");
    wr(3'd4, 32'd2);
    k = cyc;
    wait_until(k + 12);
    rd(3'd4, 32'd0, "pio_no_retrig");
    start_in = 1'b0;

    // Continuous mode, PERIOD=2 REPEAT=1, then ABORT
    wr(3'd1, 32'd2);
    wr(3'd2, 32'd1);
    wr(3'd0, 32'h3);
    wr(3'd0, 32'hB);
    k = cyc;
    exp_q.push_back(k + 4);
    exp_q.push_back(k + 7);
    exp_q.push_back(k + 11);
    exp_q.push_back(k + 14);
    exp_q.push_back(k + 18);
    exp_q.push_back(k + 21);
    wait_until(k + 22);
    wr(3'd0, 32'h13);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rd(3'd4, 32'd0, "abort_status");
    rd(3'd3, 32'd2, "abort_count_hold");
    rd(3'd5, 32'd1, "abort_left_hold");

    // SW_START while busy sets OVERRUN, schedule unchanged
    wr(3'd1, 32'd4);
    wr(3'd2, 32'd2);
    wr(3'd0, 32'h9);
    k = cyc;
    exp_q.push_back(k + 6);
    exp_q.push_back(k + 11);
    exp_q.push_back(k + 16);
    wr(3'd0, 32'h9);
    wait_until(k + 18);
    rd(3'd4, 32'd6, "overrun_status");
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    wr(3'd4, 32'd6);
    rd(3'd4, 32'd0, "overrun_w1c");

    // ABORT+SW_START in one write from IDLE
    wr(3'd0, 32'h19);
    k = cyc;
    wait_until(k + 6);
    chk("abort_sw_busy", {31'd0, busy}, 32'd0);
    rd(3'd4, 32'd0, "abort_sw_status");

    // Reset mid-RUN with PERIOD=100
    wr(3'd1, 32'd100);
    wr(3'd0, 32'hD);
    k = cyc;
    wait_until(k + 10);
    chk("run_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_tick", {31'd0, tick_out}, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    rd(3'd4, 32'd0, "arst_status");
    rd(3'd1, 32'd0, "arst_period");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
